// File: rtl/led_counter_bank.sv
// Bank of independent LED counters stepped from one shared prescaler tick.
// Each channel has its own mode (hold/up/down/bounce) and power-of-two sub-divider.
module led_counter_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 1000000,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [CW-1:0]             cfg_ch,
  input  logic [1:0]                cfg_mode,
  input  logic [3:0]                cfg_div,
  input  logic                      cfg_clr,
  output logic                      tick,
  output logic [CHANNELS*WIDTH-1:0] count_out,
  output logic [CHANNELS-1:0]       wrap
);

  localparam int              PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'd0,
    MODE_UP     = 2'd1,
    MODE_DOWN   = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  logic [PW-1:0] presc;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the async reset sits in the sensitivity list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      tick  <= 1'b0;
    end else if (presc == PRESC_MAX) begin
      presc <= '0;
      tick  <= 1'b1;
    end else begin
      presc <= presc + PW'(1);
      tick  <= 1'b0;
    end
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [WIDTH-1:0] count, count_nx;
    logic [14:0]      sub, sub_max;
    logic             dir, dir_nx, wrap_q, wrap_nx;
    mode_e            mode;
    logic [3:0]       div;
    logic             sel, step;

    // Out-of-range channel indices never match any n, so such writes are dropped.
    assign sel     = cfg_we && (cfg_ch == CW'(n));
    assign sub_max = 15'((16'd1 << div) - 16'd1);
    assign step    = (sub == sub_max);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
      count_nx = count;
      dir_nx   = dir;
      wrap_nx  = 1'b0;
      case (mode)
        MODE_UP: begin
          count_nx = count + CNT_ONE;
          wrap_nx  = (count == CNT_MAX);
        end
        MODE_DOWN: begin
          count_nx = count - CNT_ONE;
          wrap_nx  = (count == '0);
        end
        MODE_BOUNCE: begin
          if (!dir) begin
            if (count == CNT_MAX) begin
              dir_nx   = 1'b1;
              count_nx = CNT_MAX - CNT_ONE;
              wrap_nx  = 1'b1;
            end else begin
              count_nx = count + CNT_ONE;
            end
          end else begin
            if (count == '0) begin
              dir_nx   = 1'b0;
              count_nx = CNT_ONE;
              wrap_nx  = 1'b1;
            end else begin
              count_nx = count - CNT_ONE;
            end
          end
        end
        default: ;
      endcase
    end

    // A config write on this channel takes priority over a coincident step.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count  <= '0;
        sub    <= '0;
        dir    <= 1'b0;
        mode   <= MODE_UP;
        div    <= '0;
        wrap_q <= 1'b0;
      end else if (sel) begin
        mode   <= mode_e'(cfg_mode);
        div    <= cfg_div;
        sub    <= '0;
        dir    <= 1'b0;
        wrap_q <= 1'b0;
        if (cfg_clr) count <= '0;
      end else begin
        wrap_q <= 1'b0;
        if (tick) begin
          if (step) begin
            sub    <= '0;
            count  <= count_nx;
            dir    <= dir_nx;
            wrap_q <= wrap_nx;
          end else begin
            sub <= sub + 15'd1;
          end
        end
      end
    end

    assign count_out[n*WIDTH +: WIDTH] = count;
    assign wrap[n]                     = wrap_q;
  end

endmodule
